// File: rtl/mem_write_checker.sv
// Checks a DUT's memory stores against a small table of expected writes and
// reports pass, mismatch or timeout for each run.
module mem_write_checker #(
    parameter int                ADDR_W   = 32,
    parameter int                DATA_W   = 32,
    parameter int                DEPTH    = 4,
    parameter int                TIMEOUT  = 1024,
    parameter bit                ORDERED  = 1'b1,
    parameter logic [ADDR_W-1:0] IGN_BASE = ADDR_W'(96),
    parameter logic [ADDR_W-1:0] IGN_MASK = ADDR_W'('hFFFFFFFF)
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     mem_write,
    input  logic [ADDR_W-1:0]        data_adr,
    input  logic [DATA_W-1:0]        write_data,
    input  logic                     exp_we,
    input  logic [$clog2(DEPTH)-1:0] exp_idx,
    input  logic [ADDR_W-1:0]        exp_adr,
    input  logic [DATA_W-1:0]        exp_data,
    input  logic [$clog2(DEPTH):0]   num_exp,
    input  logic                     start,
    output logic                     busy,
    output logic                     pass,
    output logic                     fail,
    output logic [1:0]               fail_code,
    output logic [$clog2(DEPTH):0]   match_count,
    output logic [ADDR_W-1:0]        fail_adr,
    output logic [DATA_W-1:0]        fail_data
);

    localparam int IDX_W  = $clog2(DEPTH);
    localparam int CNT_W  = IDX_W + 1;
    localparam int TCNT_W = $clog2(TIMEOUT + 1);
    localparam logic [TCNT_W-1:0] T_LAST  = TCNT_W'(TIMEOUT - 1);
    localparam logic [CNT_W-1:0]  DEPTH_C = CNT_W'(DEPTH);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_PASS,
        ST_FAIL
    } state_t;

    state_t              state_q;
    logic [ADDR_W-1:0]   expAdr_q  [DEPTH];
    logic [DATA_W-1:0]   expData_q [DEPTH];
    logic [DEPTH-1:0]    matched_q;
    logic [CNT_W-1:0]    numExp_q;
    logic [CNT_W-1:0]    matchCount_q;
    logic [TCNT_W-1:0]   cycleCnt_q;
    logic                busy_q;
    logic                pass_q;
    logic                fail_q;
    logic [1:0]          failCode_q;
    logic [ADDR_W-1:0]   failAdr_q;
    logic [DATA_W-1:0]   failData_q;

    logic                storeValid;
    logic                hit;
    logic [IDX_W-1:0]    hitIdx;
    logic [CNT_W-1:0]    matchCount_d;
    logic [CNT_W-1:0]    numExp_d;
    logic                timeUp;

    // Any-order mode scans downward so the lowest eligible entry wins.
    always_comb begin
        storeValid   = mem_write && ((data_adr & IGN_MASK) != (IGN_BASE & IGN_MASK));
        hit          = 1'b0;
        hitIdx       = '0;
        matchCount_d = matchCount_q + 1'b1;
        numExp_d     = (num_exp > DEPTH_C) ? DEPTH_C : num_exp;
        timeUp       = (cycleCnt_q == T_LAST);
        if (ORDERED) begin
            hitIdx = matchCount_q[IDX_W-1:0];
            hit    = (expAdr_q[hitIdx] == data_adr) && (expData_q[hitIdx] == write_data);
        end else begin
            for (int i = DEPTH - 1; i >= 0; i--) begin
                if ((CNT_W'(i) < numExp_q) && !matched_q[i] &&
                    (expAdr_q[i] == data_adr) && (expData_q[i] == write_data)) begin
                    hit    = 1'b1;
                    hitIdx = IDX_W'(i);
                end
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= ST_IDLE;
            for (int i = 0; i < DEPTH; i++) begin
                expAdr_q[i]  <= '0;
                expData_q[i] <= '0;
            end
            matched_q    <= '0;
            numExp_q     <= '0;
            matchCount_q <= '0;
            cycleCnt_q   <= '0;
            busy_q       <= 1'b0;
            pass_q       <= 1'b0;
            fail_q       <= 1'b0;
            failCode_q   <= 2'd0;
            failAdr_q    <= '0;
            failData_q   <= '0;
        end else begin
            case (state_q)
                ST_RUN: begin
                    cycleCnt_q <= cycleCnt_q + 1'b1;
                    if (storeValid && hit) begin
                        matched_q[hitIdx] <= 1'b1;
                        matchCount_q      <= matchCount_d;
                        if (matchCount_d == numExp_q) begin
                            state_q <= ST_PASS;
                            busy_q  <= 1'b0;
                            pass_q  <= 1'b1;
                        end else if (timeUp) begin
                            state_q    <= ST_FAIL;
                            busy_q     <= 1'b0;
                            fail_q     <= 1'b1;
                            failCode_q <= 2'd2;
                        end
                    end else if (storeValid) begin
                        state_q    <= ST_FAIL;
                        busy_q     <= 1'b0;
                        fail_q     <= 1'b1;
                        failCode_q <= 2'd1;
                        failAdr_q  <= data_adr;
                        failData_q <= write_data;
                    end else if (timeUp) begin
                        state_q    <= ST_FAIL;
                        busy_q     <= 1'b0;
                        fail_q     <= 1'b1;
                        failCode_q <= 2'd2;
                    end
                end
                default: begin
                    if (exp_we) begin
                        expAdr_q[exp_idx]  <= exp_adr;
                        expData_q[exp_idx] <= exp_data;
                    end
                    if (start) begin
                        matched_q    <= '0;
                        numExp_q     <= numExp_d;
                        matchCount_q <= '0;
                        cycleCnt_q   <= '0;
                        fail_q       <= 1'b0;
                        failCode_q   <= 2'd0;
                        failAdr_q    <= '0;
                        failData_q   <= '0;
                        if (num_exp == '0) begin
                            state_q <= ST_PASS;
                            busy_q  <= 1'b0;
                            pass_q  <= 1'b1;
                        end else begin
                            state_q <= ST_RUN;
                            busy_q  <= 1'b1;
                            pass_q  <= 1'b0;
                        end
                    end
                end
            endcase
        end
    end

    assign busy        = busy_q;
    assign pass        = pass_q;
    assign fail        = fail_q;
    assign fail_code   = failCode_q;
    assign match_count = matchCount_q;
    assign fail_adr    = failAdr_q;
    assign fail_data   = failData_q;

endmodule

// File: tb/tb_mem_write_checker.sv
// Drives an in-order and an any-order checker with the same directed stimulus
// and compares both against expectations queued alongside each step.
module tb_mem_write_checker;

    typedef struct packed {
        logic        busy;
        logic        pass;
        logic        fail;
        logic [1:0]  code;
        logic [2:0]  count;
        logic [31:0] adr;
        logic [31:0] data;
    } snap_t;

    typedef struct {
        string tag;
        snap_t ord;
        snap_t any;
    } exp_t;

    logic        clk;
    logic        reset;
    logic        memWrite;
    logic [31:0] dataAdr;
    logic [31:0] writeData;
    logic        expWe;
    logic [1:0]  expIdx;
    logic [31:0] expAdr;
    logic [31:0] expData;
    logic [2:0]  numExp;
    logic        start;

    logic        busyO, passO, failO, busyA, passA, failA;
    logic [1:0]  codeO, codeA;
    logic [2:0]  countO, countA;
    logic [31:0] adrO, dataO, adrA, dataA;

    exp_t expQ[$];
    int   checks   = 0;
    int   failures = 0;

    mem_write_checker #(.TIMEOUT(16), .ORDERED(1'b1)) dutOrd (
        .clk(clk), .reset(reset), .mem_write(memWrite), .data_adr(dataAdr),
        .write_data(writeData), .exp_we(expWe), .exp_idx(expIdx), .exp_adr(expAdr),
        .exp_data(expData), .num_exp(numExp), .start(start), .busy(busyO),
        .pass(passO), .fail(failO), .fail_code(codeO), .match_count(countO),
        .fail_adr(adrO), .fail_data(dataO)
    );

    mem_write_checker #(.TIMEOUT(16), .ORDERED(1'b0)) dutAny (
        .clk(clk), .reset(reset), .mem_write(memWrite), .data_adr(dataAdr),
        .write_data(writeData), .exp_we(expWe), .exp_idx(expIdx), .exp_adr(expAdr),
        .exp_data(expData), .num_exp(numExp), .start(start), .busy(busyA),
        .pass(passA), .fail(failA), .fail_code(codeA), .match_count(countA),
        .fail_adr(adrA), .fail_data(dataA)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $error("[TB] FAIL watchdog observed=no_finish required=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    function automatic snap_t mk(input logic b, input logic p, input logic f,
                                 input logic [1:0] c, input logic [2:0] n,
                                 input logic [31:0] a, input logic [31:0] d);
        snap_t s;
        s.busy  = b;
        s.pass  = p;
        s.fail  = f;
        s.code  = c;
        s.count = n;
        s.adr   = a;
        s.data  = d;
        return s;
    endfunction

    function automatic string fmt(input snap_t s);
        return $sformatf("busy=%0b pass=%0b fail=%0b code=%0d count=%0d adr=%0d data=%0d",
                         s.busy, s.pass, s.fail, s.code, s.count, s.adr, s.data);
    endfunction

    task automatic pushExp(input string tag, input snap_t xo, input snap_t xa);
        exp_t e;
        e.tag = tag;
        e.ord = xo;
        e.any = xa;
        expQ.push_back(e);
    endtask

    task automatic checkOutput();
        exp_t  e;
        snap_t o;
        snap_t a;
        checks++;
        assert (expQ.size() != 0) else begin
            failures++;
            $error("[TB] FAIL scoreboard observed=empty required=pending_entry");
        end
        if (expQ.size() != 0) begin
            e = expQ.pop_front();
            o = {busyO, passO, failO, codeO, countO, adrO, dataO};
            a = {busyA, passA, failA, codeA, countA, adrA, dataA};
            checks++;
            assert (o === e.ord) else begin
                failures++;
                $error("[TB] FAIL %s/ord observed(%s) required(%s)", e.tag, fmt(o), fmt(e.ord));
            end
            checks++;
            assert (a === e.any) else begin
                failures++;
                $error("[TB] FAIL %s/any observed(%s) required(%s)", e.tag, fmt(a), fmt(e.any));
            end
        end
    endtask

    task automatic applyStimulus(input string tag, input logic we, input logic [1:0] idx,
                                 input logic [31:0] ea, input logic [31:0] ed,
                                 input logic st, input logic [2:0] n,
                                 input logic mw, input logic [31:0] a, input logic [31:0] d,
                                 input snap_t xo, input snap_t xa);
        expWe     = we;
        expIdx    = idx;
        expAdr    = ea;
        expData   = ed;
        start     = st;
        numExp    = n;
        memWrite  = mw;
        dataAdr   = a;
        writeData = d;
        pushExp(tag, xo, xa);
        @(posedge clk);
        #1;
        expWe    = 1'b0;
        start    = 1'b0;
        memWrite = 1'b0;
        checkOutput();
    endtask

    task automatic idle(input string tag, input snap_t xo, input snap_t xa);
        applyStimulus(tag, 1'b0, 2'd0, 0, 0, 1'b0, 3'd0, 1'b0, 0, 0, xo, xa);
    endtask

    task automatic load(input string tag, input logic [1:0] idx, input logic [31:0] ea,
                        input logic [31:0] ed, input snap_t xo, input snap_t xa);
        applyStimulus(tag, 1'b1, idx, ea, ed, 1'b0, 3'd0, 1'b0, 0, 0, xo, xa);
    endtask

    task automatic go(input string tag, input logic [2:0] n, input snap_t xo, input snap_t xa);
        applyStimulus(tag, 1'b0, 2'd0, 0, 0, 1'b1, n, 1'b0, 0, 0, xo, xa);
    endtask

    task automatic store(input string tag, input logic [31:0] a, input logic [31:0] d,
                         input snap_t xo, input snap_t xa);
        applyStimulus(tag, 1'b0, 2'd0, 0, 0, 1'b0, 3'd0, 1'b1, a, d, xo, xa);
    endtask

    initial begin
        snap_t sZero, sRun0, sRun1, sPass0, sPass1, sTimeout;
        sZero    = mk(0, 0, 0, 0, 0, 0, 0);
        sRun0    = mk(1, 0, 0, 0, 0, 0, 0);
        sRun1    = mk(1, 0, 0, 0, 1, 0, 0);
        sPass0   = mk(0, 1, 0, 0, 0, 0, 0);
        sPass1   = mk(0, 1, 0, 0, 1, 0, 0);
        sTimeout = mk(0, 0, 1, 2, 0, 0, 0);

        reset     = 1'b0;
        memWrite  = 1'b0;
        dataAdr   = '0;
        writeData = '0;
        expWe     = 1'b0;
        expIdx    = '0;
        expAdr    = '0;
        expData   = '0;
        numExp    = '0;
        start     = 1'b0;

        idle("reset_a", sZero, sZero);
        idle("reset_b", sZero, sZero);
        reset = 1'b1;
        idle("idle_after_reset", sZero, sZero);

        load("s1_load", 2'd0, 100, 7, sZero, sZero);
        go("s1_start", 3'd1, sRun0, sRun0);
        store("s1_ignored", 96, 3, sRun0, sRun0);
        store("s1_match", 100, 7, sPass1, sPass1);

        go("s2_start", 3'd1, sRun0, sRun0);
        store("s2_mismatch", 100, 8, mk(0, 0, 1, 1, 0, 100, 8), mk(0, 0, 1, 1, 0, 100, 8));

        go("s3_start", 3'd1, sRun0, sRun0);
        for (int i = 1; i < 16; i++) begin
            idle($sformatf("s3_wait%0d", i), sRun0, sRun0);
        end
        idle("s3_timeout", sTimeout, sTimeout);

        load("s4_load0", 2'd0, 4, 1, sTimeout, sTimeout);
        load("s4_load1", 2'd1, 8, 2, sTimeout, sTimeout);
        go("s4_start", 3'd2, sRun0, sRun0);
        store("s4_first", 8, 2, mk(0, 0, 1, 1, 0, 8, 2), sRun1);
        store("s4_second", 4, 1, mk(0, 0, 1, 1, 0, 8, 2), mk(0, 1, 0, 0, 2, 0, 0));

        // Table writes and restarts are attempted mid-run; the final store lands on the timeout edge.
        go("s5_start", 3'd1, sRun0, sRun0);
        applyStimulus("s5_we_in_run", 1'b1, 2'd0, 50, 50, 1'b0, 3'd0, 1'b0, 0, 0, sRun0, sRun0);
        go("s5_start_in_run", 3'd2, sRun0, sRun0);
        for (int i = 3; i < 16; i++) begin
            idle($sformatf("s5_wait%0d", i), sRun0, sRun0);
        end
        store("s5_match_on_timeout", 4, 1, sPass1, sPass1);

        go("s6_empty_run", 3'd0, sPass0, sPass0);

        load("s7_load", 2'd0, 100, 7, sPass0, sPass0);
        go("s7_start", 3'd2, sRun0, sRun0);
        store("s7_first", 100, 7, sRun1, sRun1);
        reset = 1'b0;
        pushExp("s7_async_reset", sZero, sZero);
        #1;
        checkOutput();
        idle("s7_reset_held", sZero, sZero);
        reset = 1'b1;
        store("s7_store_in_idle", 100, 7, sZero, sZero);
        go("s7_restart", 3'd1, sRun0, sRun0);
        store("s7_table_cleared", 100, 7, mk(0, 0, 1, 1, 0, 100, 7), mk(0, 0, 1, 1, 0, 100, 7));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/mem_write_checker.md
MEM_WRITE_CHECKER -- requirements
Module: mem_write_checker

Interface
REQ-001 SHALL have parameters, one per line: name, default, meaning.
- ADDR_W, 32, address width.
- DATA_W, 32, data width.
- DEPTH, 4, expected-write table entries (power of 2, >=2).
- TIMEOUT, 1024, cycles allowed per run.
- ORDERED, 1, 1 = in-order matching, 0 = any-order matching.
- IGN_BASE, 96, ignored-address base.
- IGN_MASK, 'hFFFFFFFF, ignored-address compare mask.

REQ-002 SHALL have ports, one per line: name direction width meaning.
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- mem_write  in  1  DUT store strobe.
- data_adr  in  ADDR_W  store address.
- write_data  in  DATA_W  store data.
- exp_we  in  1  table write enable.
- exp_idx  in  log2(DEPTH)  table index.
- exp_adr  in  ADDR_W  expected address.
- exp_data  in  DATA_W  expected data.
- num_exp  in  log2(DEPTH)+1  number of valid entries.
- start  in  1  begin run.
- busy  out  1  run active.
- pass  out  1  run succeeded.
- fail  out  1  run failed.
- fail_code  out  2  0 none, 1 mismatch, 2 timeout.
- match_count  out  log2(DEPTH)+1  entries matched.
- fail_adr  out  ADDR_W  captured failing address.
- fail_data  out  DATA_W  captured failing data.

Function
REQ-003 SHALL implement FSM IDLE, RUN, PASS, FAIL; busy=1 only in RUN; pass=1 only in PASS; fail=1 only in FAIL.
REQ-004 SHALL write the table on the rising edge with exp_we=1 in IDLE, PASS or FAIL; exp_we in RUN SHALL be ignored.
REQ-005 SHALL, on start=1 in IDLE/PASS/FAIL, enter RUN next edge, clearing match_count, cycle counter, matched bitmap, fail_code, fail_adr, fail_data, and latching num_exp; table SHALL be retained.
REQ-006 SHALL ignore start while in RUN.
REQ-007 SHALL, on start with num_exp=0, go to PASS instead of RUN.
REQ-008 SHALL, in RUN, ignore a store when (data_adr & IGN_MASK) == (IGN_BASE & IGN_MASK).
REQ-009 SHALL treat ORDERED=1 as: a non-ignored store matches only when data_adr and write_data equal entry[match_count].
REQ-010 SHALL treat ORDERED=0 as: a non-ignored store matches the lowest-index entry below num_exp that is unmatched and equal in both fields, then sets its bitmap bit.
REQ-011 SHALL, on match, increment match_count; when it reaches the latched num_exp, go to PASS on the same edge.
REQ-012 SHALL, on a non-ignored non-matching store, go to FAIL with fail_code=1 and capture data_adr/write_data into fail_adr/fail_data.
REQ-013 SHALL count RUN cycles; when TIMEOUT cycles elapse without PASS/FAIL, go to FAIL with fail_code=2 and fail_adr/fail_data=0.
REQ-014 SHALL give a completing match priority over timeout on the same edge.
REQ-015 SHALL have a single-edge latency: a store sampled on edge N is reflected in outputs after edge N.
REQ-016 SHALL ignore mem_write outside RUN.
REQ-017 SHALL register all outputs, with no combinational path from inputs.

Reset
REQ-018 SHALL, while reset=0, force IDLE with busy, pass, fail, fail_code, match_count, fail_adr and fail_data all 0.
REQ-019 SHALL clear table contents and bitmap on reset.
REQ-020 SHALL abort an active run on reset, with no pass/fail pulse.

Verification
REQ-021 SHALL cover these directed scenarios:
- entry0=(100,7), num_exp=1, start; stores (96,3), then (100,7) -> pass=1, match_count=1, fail_code=0.
- same setup; store (100,8) -> fail=1, fail_code=1, fail_adr=100, fail_data=8.
- TIMEOUT=16, num_exp=1, no stores -> fail=1, fail_code=2 exactly 16 cycles after RUN entry.
- entries (4,1),(8,2), num_exp=2; stores (8,2),(4,1) -> ORDERED=1: fail, fail_adr=8; ORDERED=0: pass, match_count=2.
- final matching store on the timeout edge -> pass=1, fail=0.
- reset=0 mid-run after 1 match, then restart without reloading -> all outputs 0, table empty, store (100,7) fails.
